// File: rtl/pu_or1k_bus_if_wb_burst.sv
// Wishbone B3 master for the OR1K request port: single and wrapping-burst transfers,
// rty retry with optional limit, clean abort on err.
//   state  | meaning
//   IDLE   | no cycle on the bus, waiting for cpu_req_i
//   SINGLE | classic single-beat cycle in progress
//   BURST  | incrementing wrap burst in progress
//   RETRY  | one-cycle cyc/stb gap after rty before reissuing the beat
module pu_or1k_bus_if_wb_burst #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int BURST_LENGTH = 8,
    parameter int MAX_RETRY    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req_i,
    input  logic [ADDR_WIDTH-1:0]   cpu_adr_i,
    input  logic                    cpu_we_i,
    input  logic [DATA_WIDTH/8-1:0] cpu_bsel_i,
    input  logic                    cpu_burst_i,
    input  logic [DATA_WIDTH-1:0]   cpu_dat_i,
    output logic                    cpu_ack_o,
    output logic                    cpu_err_o,
    output logic [DATA_WIDTH-1:0]   cpu_dat_o,
    output logic                    busy_o,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
    output logic [2:0]              wbm_cti_o,
    output logic [1:0]              wbm_bte_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    input  logic                    wbm_rty_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i
);
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(SEL_W);
    localparam int BW    = $clog2(BURST_LENGTH);
    localparam int BCW   = (BW > 0) ? BW : 1;
    localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [ADDR_WIDTH-1:0] WRAP_MASK  = ADDR_WIDTH'((BURST_LENGTH - 1) << OFF_W);
    localparam logic [ADDR_WIDTH-1:0] BEAT_STEP  = ADDR_WIDTH'(1 << OFF_W);
    localparam logic [BCW-1:0]        LAST_BEAT  = BCW'(BURST_LENGTH - 1);
    localparam logic [RW-1:0]         RETRY_LAST = RW'((MAX_RETRY > 0) ? MAX_RETRY - 1 : 0);
    localparam logic [1:0]            BURST_BTE  = (BURST_LENGTH == 4)  ? 2'b01 :
                                                   (BURST_LENGTH == 8)  ? 2'b10 :
                                                   (BURST_LENGTH == 16) ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {ST_IDLE, ST_SINGLE, ST_BURST, ST_RETRY} state_t;

    state_t              state_q, state_n;
    logic [ADDR_WIDTH-1:0] adr_q, adr_n;
    logic                we_q, we_n;
    logic [SEL_W-1:0]    sel_q, sel_n;
    logic                burst_q, burst_n;
    logic [BCW-1:0]      beat_q, beat_n;
    logic [RW-1:0]       retry_q, retry_n;
    logic                cyc_q, cyc_n;
    logic [2:0]          cti_q, cti_n;
    logic [1:0]          bte_q, bte_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            burst_q <= 1'b0;
            beat_q  <= '0;
            retry_q <= '0;
            cyc_q   <= 1'b0;
            cti_q   <= 3'b000;
            bte_q   <= 2'b00;
        end else begin
            state_q <= state_n;
            adr_q   <= adr_n;
            we_q    <= we_n;
            sel_q   <= sel_n;
            burst_q <= burst_n;
            beat_q  <= beat_n;
            retry_q <= retry_n;
            cyc_q   <= cyc_n;
            cti_q   <= cti_n;
            bte_q   <= bte_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        adr_n     = adr_q;
        we_n      = we_q;
        sel_n     = sel_q;
        burst_n   = burst_q;
        beat_n    = beat_q;
        retry_n   = retry_q;
        cyc_n     = 1'b0;
        cti_n     = 3'b000;
        bte_n     = 2'b00;
        cpu_ack_o = 1'b0;
        cpu_err_o = 1'b0;
        cpu_dat_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    adr_n   = cpu_adr_i;
                    we_n    = cpu_we_i;
                    sel_n   = cpu_bsel_i;
                    burst_n = cpu_burst_i && (BURST_LENGTH > 1);
                    beat_n  = '0;
                    retry_n = '0;
                    state_n = burst_n ? ST_BURST : ST_SINGLE;
                end
            end
            ST_SINGLE, ST_BURST: begin
                if (wbm_err_i) begin
                    cpu_err_o = 1'b1;
                    state_n   = ST_IDLE;
                end else if (wbm_ack_i) begin
                    cpu_ack_o = 1'b1;
                    cpu_dat_o = wbm_dat_i;
                    retry_n   = '0;
                    if (state_q == ST_SINGLE || beat_q == LAST_BEAT) begin
                        state_n = ST_IDLE;
                    end else begin
                        // only the beat-index field wraps; offset and upper bits hold
                        beat_n = beat_q + 1'b1;
                        adr_n  = (adr_q & ~WRAP_MASK) | ((adr_q + BEAT_STEP) & WRAP_MASK);
                    end
                end else if (wbm_rty_i) begin
                    if (MAX_RETRY != 0 && retry_q == RETRY_LAST) begin
                        cpu_err_o = 1'b1;
                        state_n   = ST_IDLE;
                    end else begin
                        retry_n = retry_q + 1'b1;
                        state_n = ST_RETRY;
                    end
                end else if (state_q == ST_BURST && !cpu_req_i) begin
                    state_n = ST_IDLE;
                end
            end
            ST_RETRY: state_n = burst_q ? ST_BURST : ST_SINGLE;
            default:  state_n = ST_IDLE;
        endcase

        if (state_n == ST_IDLE) begin
            adr_n   = '0;
            we_n    = 1'b0;
            sel_n   = '0;
            burst_n = 1'b0;
            beat_n  = '0;
            retry_n = '0;
        end

        // bus controls are computed for the upcoming state so they leave the flops aligned
        if (state_n == ST_SINGLE) begin
            cyc_n = 1'b1;
            cti_n = 3'b111;
        end else if (state_n == ST_BURST) begin
            cyc_n = 1'b1;
            cti_n = (beat_n == LAST_BEAT) ? 3'b111 : 3'b010;
            bte_n = BURST_BTE;
        end

        if (rst) begin
            cpu_ack_o = 1'b0;
            cpu_err_o = 1'b0;
            cpu_dat_o = '0;
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_adr_o = adr_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_cti_o = cti_q;
    assign wbm_bte_o = bte_q;
    assign wbm_dat_o = cpu_dat_i;

endmodule

// File: tb/tb_pu_or1k_bus_if_wb_burst.sv
// Scoreboard bench: a transaction-level model plans slave responses and the expected
// bus/CPU view; a scripted slave and an independent monitor check the DUT against it.
module tb_pu_or1k_bus_if_wb_burst;
    localparam int CLK_P = 10;
    localparam int BL    = 8;
    localparam logic [2:0] C_WAIT = 3'd0, C_ACK = 3'd1, C_RTY = 3'd2, C_ERR = 3'd3,
                           C_ACKERR = 3'd4, C_ABORT = 3'd5;

    typedef struct packed {
        logic        stb;
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } bus_t;
    typedef struct packed { logic err; logic [31:0] dat; } cpu_t;
    typedef struct packed { logic [2:0] code; logic [31:0] dat; } rsp_t;

    logic clk = 1'b0;
    always #(CLK_P / 2) clk = ~clk;
    logic rst;

    logic        cpu_req_i, cpu_we_i, cpu_burst_i;
    logic [31:0] cpu_adr_i, cpu_dat_i, cpu_dat_o;
    logic [3:0]  cpu_bsel_i;
    logic        cpu_ack_o, cpu_err_o, busy_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

    logic        s_ack, s_err, s_rty, slv_abort;
    logic [31:0] s_dat;
    logic        man_ack, man_err, man_rty;
    logic [31:0] man_dat;
    logic        slave_auto, noise_en, mon_en;

    assign wbm_ack_i = slave_auto ? s_ack : man_ack;
    assign wbm_err_i = slave_auto ? s_err : man_err;
    assign wbm_rty_i = slave_auto ? s_rty : man_rty;
    assign wbm_dat_i = slave_auto ? s_dat : man_dat;

    logic        b_req, b_we, b_burst, b_ack_o, b_err_o, b_busy;
    logic [31:0] b_adr_i, b_wadr;
    logic [63:0] b_dat_i, b_dat_o, b_wdat;
    logic [7:0]  b_sel_i, b_wsel;
    logic        b_cyc, b_stb, b_wwe, b_ack, b_err, b_rty;
    logic [2:0]  b_cti;
    logic [1:0]  b_bte;
    assign b_ack = b_cyc & b_stb;
    assign b_err = 1'b0;
    assign b_rty = 1'b0;

    pu_or1k_bus_if_wb_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LENGTH(8), .MAX_RETRY(3)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_adr_i(cpu_adr_i), .cpu_we_i(cpu_we_i), .cpu_bsel_i(cpu_bsel_i),
        .cpu_burst_i(cpu_burst_i), .cpu_dat_i(cpu_dat_i), .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o),
        .cpu_dat_o(cpu_dat_o), .busy_o(busy_o),
        .wbm_adr_o(wbm_adr_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i), .wbm_dat_i(wbm_dat_i)
    );

    pu_or1k_bus_if_wb_burst #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .BURST_LENGTH(4), .MAX_RETRY(0)) u_dut64 (
        .clk(clk), .rst(rst),
        .cpu_req_i(b_req), .cpu_adr_i(b_adr_i), .cpu_we_i(b_we), .cpu_bsel_i(b_sel_i),
        .cpu_burst_i(b_burst), .cpu_dat_i(b_dat_i), .cpu_ack_o(b_ack_o), .cpu_err_o(b_err_o),
        .cpu_dat_o(b_dat_o), .busy_o(b_busy),
        .wbm_adr_o(b_wadr), .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_wwe),
        .wbm_sel_o(b_wsel), .wbm_cti_o(b_cti), .wbm_bte_o(b_bte), .wbm_dat_o(b_wdat),
        .wbm_ack_i(b_ack), .wbm_err_i(b_err), .wbm_rty_i(b_rty), .wbm_dat_i(64'h0)
    );

    int checks = 0;
    int errors = 0;

    rsp_t rsp_q[$];
    rsp_t force_q[$];
    bus_t bus_q[$];
    cpu_t cpu_q[$];
    logic [31:0] wd [BL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endtask

    // address of beat k of a wrapping burst: aligned block base plus rotated word index
    function automatic logic [31:0] beat_adr(input logic [31:0] a, input int k, input logic burst);
        int unsigned blk, base, idx;
        if (!burst) return a;
        blk  = BL * 4;
        base = a - (a % blk);
        idx  = ((a % blk) / 4 + k) % BL;
        return 32'(base + idx * 4 + (a % 4));
    endfunction

    task automatic next_rsp(input logic burst, output rsp_t r);
        int p;
        r.dat = $urandom;
        if (force_q.size() != 0) begin
            r = force_q.pop_front();
        end else begin
            p = $urandom_range(0, 99);
            if (p < 20)      r.code = C_WAIT;
            else if (p < 68) r.code = C_ACK;
            else if (p < 80) r.code = C_RTY;
            else if (p < 84) r.code = C_ERR;
            else if (p < 86) r.code = C_ACKERR;
            else if (p < 90) r.code = burst ? C_ABORT : C_WAIT;
            else             r.code = C_ACK;
        end
    endtask

    task automatic plan_txn(input logic [31:0] a, input logic we, input logic burst, input logic [3:0] sel);
        int n, k, retries;
        bit done;
        rsp_t r;
        bus_t b;
        cpu_t c;
        n = burst ? BL : 1;
        k = 0;
        retries = 0;
        done = 0;
        while (!done) begin
            next_rsp(burst, r);
            b.stb = 1'b1;
            b.adr = beat_adr(a, k, burst);
            b.cti = (!burst || k == BL - 1) ? 3'b111 : 3'b010;
            b.bte = burst ? 2'b10 : 2'b00;
            b.we  = we;
            b.sel = sel;
            b.dat = wd[k];
            bus_q.push_back(b);
            rsp_q.push_back(r);
            case (r.code)
                C_ACK: begin
                    c.err = 1'b0; c.dat = r.dat; cpu_q.push_back(c);
                    retries = 0;
                    k++;
                    done = (k == n);
                end
                C_RTY: begin
                    retries++;
                    if (retries == 3) begin
                        c.err = 1'b1; c.dat = '0; cpu_q.push_back(c);
                        done = 1;
                    end else begin
                        b.stb = 1'b0;
                        bus_q.push_back(b);
                    end
                end
                C_ERR, C_ACKERR: begin
                    c.err = 1'b1; c.dat = '0; cpu_q.push_back(c);
                    done = 1;
                end
                C_ABORT: done = 1;
                default: ;
            endcase
        end
    endtask

    task automatic drive_txn(input logic [31:0] a, input logic we, input logic burst, input logic [3:0] sel);
        int beat, n, budget;
        bit fin;
        n = burst ? BL : 1;
        @(negedge clk); #2;
        cpu_req_i = 1'b1; cpu_adr_i = a; cpu_we_i = we; cpu_burst_i = burst; cpu_bsel_i = sel;
        cpu_dat_i = wd[0];
        beat = 0; fin = 0; budget = 0;
        while (!fin) begin
            @(negedge clk); #2;
            budget++;
            if (cpu_err_o) fin = 1;
            else if (cpu_ack_o) begin
                beat++;
                if (beat == n) fin = 1;
                else cpu_dat_i = wd[beat];
            end else if (slv_abort) fin = 1;
            if (!fin && budget > 300) begin
                flag("txn_timeout", "transaction never completed");
                fin = 1;
            end
            cpu_adr_i   = $urandom;
            cpu_we_i    = 1'($urandom_range(0, 1));
            cpu_bsel_i  = 4'($urandom);
        end
        cpu_req_i = 1'b0;
    endtask

    task automatic run_txn(input logic [31:0] a, input logic we, input logic burst, input logic [3:0] sel);
        for (int i = 0; i < BL; i++) wd[i] = $urandom;
        plan_txn(a, we, burst, sel);
        drive_txn(a, we, burst, sel);
    endtask

    task automatic force_rsp(input logic [2:0] code, input logic [31:0] dat);
        rsp_t r;
        r.code = code;
        r.dat  = dat;
        force_q.push_back(r);
    endtask

    // scripted slave: one planned response per cycle with stb high, optional noise otherwise
    always @(negedge clk) begin : slave
        rsp_t r;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; slv_abort = 1'b0;
        s_dat = $urandom;
        if (slave_auto && wbm_cyc_o && wbm_stb_o) begin
            if (rsp_q.size() == 0) flag("slave_script", "bus cycle with no planned response");
            else begin
                r = rsp_q.pop_front();
                s_dat     = r.dat;
                s_ack     = (r.code == C_ACK) || (r.code == C_ACKERR);
                s_err     = (r.code == C_ERR) || (r.code == C_ACKERR);
                s_rty     = (r.code == C_RTY);
                slv_abort = (r.code == C_ABORT);
            end
        end else if (noise_en) begin
            s_ack = ($urandom_range(0, 3) == 0);
            s_err = ($urandom_range(0, 7) == 0);
            s_rty = ($urandom_range(0, 7) == 0);
        end
    end

    always @(negedge clk) begin : monitor
        bus_t e;
        cpu_t c;
        #1;
        if (mon_en) begin
            if (busy_o) begin
                if (bus_q.size() == 0) flag("bus_seq", "busy with no expected bus cycle");
                else begin
                    e = bus_q.pop_front();
                    chk("cyc", wbm_cyc_o, e.stb);
                    chk("stb", wbm_stb_o, e.stb);
                    if (e.stb) begin
                        chk("adr", wbm_adr_o, e.adr);
                        chk("cti", wbm_cti_o, e.cti);
                        chk("bte", wbm_bte_o, e.bte);
                        chk("we", wbm_we_o, e.we);
                        chk("sel", wbm_sel_o, e.sel);
                        if (e.we) chk("wdat", wbm_dat_o, e.dat);
                    end
                end
            end else begin
                chk("idle_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
                chk("idle_adr", wbm_adr_o, 0);
            end
            if (cpu_ack_o || cpu_err_o) begin
                if (cpu_q.size() == 0) flag("cpu_resp", $sformatf("unexpected ack=%0b err=%0b", cpu_ack_o, cpu_err_o));
                else begin
                    c = cpu_q.pop_front();
                    chk("cpu_ack", cpu_ack_o, !c.err);
                    chk("cpu_err", cpu_err_o, c.err);
                    chk("cpu_dat", cpu_dat_o, c.dat);
                end
            end else begin
                chk("cpu_dat_quiet", cpu_dat_o, 0);
            end
        end
    end

    initial begin
        #(CLK_P * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] w64_adr [4];
        logic [63:0] b_wd [4];
        int budget;
        w64_adr[0] = 32'h2008; w64_adr[1] = 32'h2010; w64_adr[2] = 32'h2018; w64_adr[3] = 32'h2000;
        rst = 1'b1;
        cpu_req_i = 0; cpu_adr_i = '0; cpu_we_i = 0; cpu_burst_i = 0; cpu_bsel_i = '0; cpu_dat_i = '0;
        man_ack = 0; man_err = 0; man_rty = 0; man_dat = '0;
        slave_auto = 1; noise_en = 0; mon_en = 0;
        b_req = 0; b_adr_i = '0; b_we = 0; b_burst = 0; b_sel_i = '0; b_dat_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_cti_bte", {wbm_cti_o, wbm_bte_o}, 0);
        chk("rst_we_sel", {wbm_we_o, wbm_sel_o}, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cpu_resp", {cpu_ack_o, cpu_err_o}, 0);
        chk("rst_cpu_dat", cpu_dat_o, 0);
        chk("rst64_cyc_busy", {b_cyc, b_busy}, 0);
        #1;
        rst = 1'b0;
        mon_en = 1;

        // single read, slave acks two cycles after stb
        force_rsp(C_WAIT, 0); force_rsp(C_WAIT, 0); force_rsp(C_ACK, 32'hDEADBEEF);
        run_txn(32'h100, 0, 0, 4'hF);
        // zero-wait wrapping read burst from mid-block
        for (int i = 0; i < BL; i++) force_rsp(C_ACK, $urandom);
        run_txn(32'h1018, 0, 1, 4'hF);
        // retry limit: three rty in a row fail the request
        force_rsp(C_RTY, 0); force_rsp(C_RTY, 0); force_rsp(C_RTY, 0);
        run_txn(32'h300, 0, 0, 4'h3);
        // error on beat 3, then simultaneous ack+err
        force_rsp(C_ACK, 32'h11); force_rsp(C_ACK, 32'h22); force_rsp(C_ERR, 32'h33);
        run_txn(32'h400, 0, 1, 4'hF);
        force_rsp(C_ACK, 32'h44); force_rsp(C_ACKERR, 32'h55);
        run_txn(32'h504, 1, 1, 4'hC);
        // CPU withdraws the request mid-burst
        force_rsp(C_ACK, 32'h66); force_rsp(C_WAIT, 0); force_rsp(C_ABORT, 0);
        run_txn(32'h608, 0, 1, 4'hF);

        noise_en = 1;
        for (int t = 0; t < 120; t++) begin
            run_txn($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        noise_en = 0;
        repeat (3) @(negedge clk);
        #3;
        mon_en = 0;
        chk("left_bus", bus_q.size(), 0);
        chk("left_cpu", cpu_q.size(), 0);
        chk("left_rsp", rsp_q.size(), 0);

        // reset during beat 2 of a burst
        slave_auto = 0;
        @(negedge clk); #2;
        cpu_req_i = 1; cpu_burst_i = 1; cpu_adr_i = 32'h40; cpu_we_i = 0; cpu_bsel_i = 4'hF;
        budget = 0;
        do begin
            @(negedge clk); #2;
            budget++;
        end while (!wbm_stb_o && budget < 10);
        if (!wbm_stb_o) flag("rst_test_stb", "stb never rose");
        man_ack = 1; man_dat = 32'h1234_5678;
        #1;
        chk("rst_test_beat1_ack", {cpu_ack_o, cpu_dat_o}, {1'b1, 32'h1234_5678});
        @(negedge clk); #1;
        chk("rst_test_beat2_adr", wbm_adr_o, 32'h44);
        #1;
        man_ack = 0;
        rst = 1;
        @(negedge clk); #1;
        chk("rst_mid_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("rst_mid_attr", {wbm_adr_o, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o}, 0);
        chk("rst_mid_cpu", {busy_o, cpu_ack_o, cpu_err_o, cpu_dat_o}, 0);
        #1;
        rst = 0;
        cpu_req_i = 0;

        // 64-bit write burst, zero-wait slave
        for (int k = 0; k < 4; k++) b_wd[k] = {$urandom, $urandom};
        @(negedge clk); #2;
        b_req = 1; b_adr_i = 32'h2008; b_we = 1; b_burst = 1; b_sel_i = 8'hFF; b_dat_i = b_wd[0];
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("w64_stb", b_stb, 1);
            chk("w64_adr", b_wadr, w64_adr[k]);
            chk("w64_cti", b_cti, (k == 3) ? 3'b111 : 3'b010);
            chk("w64_bte_we", {b_bte, b_wwe}, {2'b01, 1'b1});
            chk("w64_dat", b_wdat, b_wd[k]);
            chk("w64_ack", b_ack_o, 1);
            #1;
            b_adr_i = $urandom;
            if (k < 3) b_dat_i = b_wd[k + 1];
        end
        b_req = 0;
        @(negedge clk); #1;
        chk("w64_end", {b_cyc, b_busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
